// File: rtl/memory_bus_pkg.sv
// Shared encodings for the memory bus: transfer sizes, operations, arbiter states,
// the per-requester request bundle and the two-way arbitration decision.
package memory_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic OPERATION_READ  = 1'b0;
  localparam logic OPERATION_WRITE = 1'b1;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_BUSY    = 2'd1;
  localparam logic [1:0] STATE_RELEASE = 2'd2;

  typedef struct packed {
    logic        enable;
    logic        operation;
    logic [1:0]  data_size;
    logic [31:0] address;
    logic [31:0] data_out;
  } mem_req_t;

  // A tie goes to requester 0 under fixed priority, otherwise to whoever was not granted last.
  function automatic logic arb_winner(input logic i_en0, input logic i_en1,
                                      input logic i_last_grant, input logic i_fixed);
    logic v_win;
    if (i_en0 && i_en1) begin
      if (i_fixed) begin
        v_win = 1'b0;
      end else begin
        v_win = ~i_last_grant;
      end
    end else if (i_en1) begin
      v_win = 1'b1;
    end else begin
      v_win = 1'b0;
    end
    return v_win;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester arbiter onto a single downstream memory port. The owner's request is
// passed through combinationally while BUSY; RELEASE waits for memory_ready to fall.
module memory_arbiter
  import memory_bus_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        requester_0_enable,
  input  logic        requester_0_operation,
  input  logic [1:0]  requester_0_data_size,
  input  logic [31:0] requester_0_address,
  input  logic [31:0] requester_0_data_out,
  output logic [31:0] requester_0_data_in,
  output logic        requester_0_ready,

  input  logic        requester_1_enable,
  input  logic        requester_1_operation,
  input  logic [1:0]  requester_1_data_size,
  input  logic [31:0] requester_1_address,
  input  logic [31:0] requester_1_data_out,
  output logic [31:0] requester_1_data_in,
  output logic        requester_1_ready,

  output logic        memory_enable,
  output logic        memory_operation,
  output logic [1:0]  memory_data_size,
  output logic [31:0] memory_address,
  output logic [31:0] memory_data_out,
  input  logic [31:0] memory_data_in,
  input  logic        memory_ready
);

  logic [1:0] r_state;
  logic       r_owner;
  logic       r_last_grant;

  logic [1:0] w_state_next;
  logic       w_any_req;
  logic       w_winner;
  logic       w_ready_gate;
  mem_req_t   w_req0;
  mem_req_t   w_req1;
  mem_req_t   w_owner_req;

  assign w_req0 = '{enable:    requester_0_enable,
                    operation: requester_0_operation,
                    data_size: requester_0_data_size,
                    address:   requester_0_address,
                    data_out:  requester_0_data_out};
  assign w_req1 = '{enable:    requester_1_enable,
                    operation: requester_1_operation,
                    data_size: requester_1_data_size,
                    address:   requester_1_address,
                    data_out:  requester_1_data_out};

  assign w_any_req   = requester_0_enable | requester_1_enable;
  assign w_winner    = arb_winner(requester_0_enable, requester_1_enable, r_last_grant,
                                  (FIXED_PRIORITY != 0));
  assign w_owner_req = r_owner ? w_req1 : w_req0;

  // Next-state decode; an owner dropping enable ends BUSY whether or not ready was seen.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_IDLE: begin
        if (w_any_req) begin
          w_state_next = STATE_BUSY;
        end else begin
          w_state_next = STATE_IDLE;
        end
      end
      STATE_BUSY: begin
        if (!w_owner_req.enable) begin
          w_state_next = STATE_RELEASE;
        end else begin
          w_state_next = STATE_BUSY;
        end
      end
      STATE_RELEASE: begin
        if (!memory_ready) begin
          w_state_next = STATE_IDLE;
        end else begin
          w_state_next = STATE_RELEASE;
        end
      end
      default: w_state_next = STATE_IDLE;
    endcase
  end

  // State, owner and last grant; last_grant starts at 1 so requester 0 takes the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= STATE_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if ((r_state == STATE_IDLE) && w_any_req) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  // Downstream port mirrors the owner only while BUSY, otherwise it is held at zero.
  always_comb begin
    memory_enable    = 1'b0;
    memory_operation = 1'b0;
    memory_data_size = 2'd0;
    memory_address   = 32'd0;
    memory_data_out  = 32'd0;
    if (r_state == STATE_BUSY) begin
      memory_enable    = w_owner_req.enable;
      memory_operation = w_owner_req.operation;
      memory_data_size = w_owner_req.data_size;
      memory_address   = w_owner_req.address;
      memory_data_out  = w_owner_req.data_out;
    end else begin
      memory_enable    = 1'b0;
    end
  end

  assign w_ready_gate      = memory_ready & ((r_state == STATE_BUSY) | (r_state == STATE_RELEASE));
  assign requester_0_ready = w_ready_gate & ~r_owner;
  assign requester_1_ready = w_ready_gate &  r_owner;

  assign requester_0_data_in = memory_data_in;
  assign requester_1_data_in = memory_data_in;

endmodule
